// File: rtl/ssp_rx.sv
// Serial receive path: recovers 8-bit frames from SSPCLKIN/SSPFSSIN/SSPRXD into a 4-deep show-ahead FIFO.
// Define SSP_RX_OVERRUN_EN to build the sticky RX_OVERRUN flag; otherwise RX_OVERRUN is tied low.
module ssp_rx (
  input  logic       PCLK,
  input  logic       CLEAR_B,
  input  logic       SSPCLKIN,
  input  logic       SSPFSSIN,
  input  logic       SSPRXD,
  input  logic       RX_RD,
  output logic [7:0] RX_DATA,
  output logic       RX_EMPTY,
  output logic       SSPRXINTR,
  output logic       RX_OVERRUN
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [7:0] shift_q, shift_d;
  logic       clkin_q;
  logic       fall_evt;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       unused_shift_msb;

  logic [7:0] mem_q [0:3];
  logic [2:0] wp_q, rp_q;
  logic [2:0] occ;
  logic       full;
  logic       empty;
  logic       rd_ok;
  logic       wr_ok;

  // Falling SSPCLKIN is the only instant the link pins are sampled.
  assign fall_evt         = clkin_q & ~SSPCLKIN;
  assign unused_shift_msb = shift_q[7];

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q <= IDLE;
      count_q <= 3'd0;
      shift_q <= 8'h00;
      clkin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      clkin_q <= SSPCLKIN;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (fall_evt && SSPFSSIN) begin
          state_d = SHIFT;
          count_d = 3'd0;
        end
      end
      SHIFT: begin
        if (fall_evt) begin
          shift_d = {shift_q[6:0], SSPRXD};
          count_d = count_q + 3'd1;
          // A sync pulse on the last bit starts the next frame with no gap.
          if (count_q == 3'd7) begin
            state_d = SSPFSSIN ? SHIFT : IDLE;
            count_d = 3'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en   = (state_q == SHIFT) && fall_evt && (count_q == 3'd7);
    wr_data = {shift_q[6:0], SSPRXD};
  end

  assign occ       = wp_q - rp_q;
  assign full      = (occ == 3'd4);
  assign empty     = (occ == 3'd0);
  assign rd_ok     = RX_RD & ~empty;
  // A pop on the same edge frees the slot, so a write at full still lands.
  assign wr_ok     = wr_en & (~full | rd_ok);
  assign RX_DATA   = mem_q[rp_q[1:0]];
  assign RX_EMPTY  = empty;
  assign SSPRXINTR = full;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
      wp_q <= 3'd0;
      rp_q <= 3'd0;
    end else begin
      if (wr_ok) begin
        mem_q[wp_q[1:0]] <= wr_data;
        wp_q             <= wp_q + 3'd1;
      end
      if (rd_ok) rp_q <= rp_q + 3'd1;
    end
  end

`ifdef SSP_RX_OVERRUN_EN
  logic ovr_q;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) ovr_q <= 1'b0;
    else if (wr_en && full && !rd_ok) ovr_q <= 1'b1;
  end

  assign RX_OVERRUN = ovr_q;
`else
  assign RX_OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_rx.sv
// Scoreboard bench for ssp_rx: frames are bit-banged at PCLK/2 and expected words are queued as they are sent.
module tb_ssp_rx;

  logic       PCLK;
  logic       CLEAR_B;
  logic       SSPCLKIN;
  logic       SSPFSSIN;
  logic       SSPRXD;
  logic       RX_RD;
  logic [7:0] RX_DATA;
  logic       RX_EMPTY;
  logic       SSPRXINTR;
  logic       RX_OVERRUN;

  int         vectors;
  int         miscompares;
  logic [7:0] sb[$];
  logic       expOvr;
  logic [7:0] exp;

  ssp_rx dut (
    .PCLK(PCLK),
    .CLEAR_B(CLEAR_B),
    .SSPCLKIN(SSPCLKIN),
    .SSPFSSIN(SSPFSSIN),
    .SSPRXD(SSPRXD),
    .RX_RD(RX_RD),
    .RX_DATA(RX_DATA),
    .RX_EMPTY(RX_EMPTY),
    .SSPRXINTR(SSPRXINTR),
    .RX_OVERRUN(RX_OVERRUN)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic logic ovrRequired();
`ifdef SSP_RX_OVERRUN_EN
    return expOvr;
`else
    return 1'b0;
`endif
  endfunction

  task automatic resetDut();
    @(negedge PCLK);
    CLEAR_B  = 1'b0;
    SSPCLKIN = 1'b0;
    SSPFSSIN = 1'b0;
    SSPRXD   = 1'b0;
    RX_RD    = 1'b0;
    sb.delete();
    expOvr = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    @(negedge PCLK);
  endtask

  // One SSPCLKIN period; the sampling event is the posedge right after this returns.
  task automatic sendBit(input logic fss, input logic d, input logic rd);
    @(negedge PCLK);
    SSPCLKIN = 1'b1;
    SSPFSSIN = fss;
    SSPRXD   = d;
    RX_RD    = 1'b0;
    @(negedge PCLK);
    SSPCLKIN = 1'b0;
    RX_RD    = rd;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic sync, input logic fssLast, input logic rdLast);
    if (sync) sendBit(1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--)
      sendBit((i == 0) ? fssLast : 1'b0, d[i], (i == 0) ? rdLast : 1'b0);
    if (rdLast && sb.size() > 0) void'(sb.pop_front());
    if (sb.size() < 4) sb.push_back(d);
    else expOvr = 1'b1;
  endtask

  task automatic settle();
    @(negedge PCLK);
    RX_RD = 1'b0;
  endtask

  task automatic pulseRead();
    @(negedge PCLK);
    RX_RD = 1'b1;
    @(negedge PCLK);
    RX_RD = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    CLEAR_B = 1'b0;
    @(negedge PCLK);
    vectors++;
    if (RX_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h exp=00", RX_DATA); end
    vectors++;
    if (RX_EMPTY !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", RX_EMPTY); end
    vectors++;
    if (SSPRXINTR !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", SSPRXINTR); end
    vectors++;
    if (RX_OVERRUN !== 1'b0) begin miscompares++; $display("FAIL reset_ovr got=%b exp=0", RX_OVERRUN); end
    resetDut();
  endtask

  task automatic test_single();
    sendFrame(8'hA5, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (RX_EMPTY !== 1'b1) begin miscompares++; $display("FAIL single_early_empty got=%b exp=1", RX_EMPTY); end
    settle();
    exp = sb.pop_front();
    vectors++;
    if (RX_EMPTY !== 1'b0) begin miscompares++; $display("FAIL single_empty got=%b exp=0", RX_EMPTY); end
    vectors++;
    if (RX_DATA !== exp) begin miscompares++; $display("FAIL single_data got=%h exp=%h", RX_DATA, exp); end
    pulseRead();
    vectors++;
    if (RX_EMPTY !== 1'b1) begin miscompares++; $display("FAIL single_drained got=%b exp=1", RX_EMPTY); end
  endtask

  task automatic test_back_to_back();
    sendFrame(8'h3C, 1'b1, 1'b1, 1'b0);
    sendFrame(8'hC3, 1'b0, 1'b0, 1'b0);
    settle();
    for (int i = 0; i < 2; i++) begin
      exp = sb.pop_front();
      vectors++;
      if (RX_EMPTY !== 1'b0) begin miscompares++; $display("FAIL b2b_empty[%0d] got=%b exp=0", i, RX_EMPTY); end
      vectors++;
      if (RX_DATA !== exp) begin miscompares++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, RX_DATA, exp); end
      pulseRead();
    end
    vectors++;
    if (RX_EMPTY !== 1'b1) begin miscompares++; $display("FAIL b2b_drained got=%b exp=1", RX_EMPTY); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      sendFrame(i[7:0], 1'b1, 1'b0, 1'b0);
      settle();
      vectors++;
      if (SSPRXINTR !== (i >= 4)) begin miscompares++; $display("FAIL ovr_full[%0d] got=%b exp=%b", i, SSPRXINTR, (i >= 4)); end
      vectors++;
      if (RX_OVERRUN !== ovrRequired()) begin miscompares++; $display("FAIL ovr_flag[%0d] got=%b exp=%b", i, RX_OVERRUN, ovrRequired()); end
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      vectors++;
      if (RX_DATA !== exp || RX_EMPTY !== 1'b0) begin
        miscompares++; $display("FAIL ovr_read got=%h/empty=%b exp=%h/empty=0", RX_DATA, RX_EMPTY, exp);
      end
      pulseRead();
    end
    vectors++;
    if (RX_EMPTY !== 1'b1) begin miscompares++; $display("FAIL ovr_drained got=%b exp=1", RX_EMPTY); end
  endtask

  task automatic test_read_write_full();
    resetDut();
    for (int i = 1; i <= 4; i++) sendFrame(8'(i * 8'h11), 1'b1, 1'b0, 1'b0);
    settle();
    vectors++;
    if (SSPRXINTR !== 1'b1) begin miscompares++; $display("FAIL rwf_full_before got=%b exp=1", SSPRXINTR); end
    vectors++;
    if (RX_DATA !== sb[0]) begin miscompares++; $display("FAIL rwf_head got=%h exp=%h", RX_DATA, sb[0]); end
    sendFrame(8'h55, 1'b1, 1'b0, 1'b1);
    settle();
    vectors++;
    if (SSPRXINTR !== 1'b1) begin miscompares++; $display("FAIL rwf_full_after got=%b exp=1", SSPRXINTR); end
    vectors++;
    if (RX_OVERRUN !== 1'b0) begin miscompares++; $display("FAIL rwf_ovr got=%b exp=0", RX_OVERRUN); end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      vectors++;
      if (RX_DATA !== exp || RX_EMPTY !== 1'b0) begin
        miscompares++; $display("FAIL rwf_read got=%h/empty=%b exp=%h/empty=0", RX_DATA, RX_EMPTY, exp);
      end
      pulseRead();
    end
    vectors++;
    if (RX_EMPTY !== 1'b1) begin miscompares++; $display("FAIL rwf_drained got=%b exp=1", RX_EMPTY); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      sendFrame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
      settle();
      if (sb.size() >= 3) begin
        exp = sb.pop_front();
        vectors++;
        if (RX_DATA !== exp) begin miscompares++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, RX_DATA, exp); end
        pulseRead();
      end
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      vectors++;
      if (RX_DATA !== exp || RX_EMPTY !== 1'b0) begin
        miscompares++; $display("FAIL wrap_drain got=%h/empty=%b exp=%h/empty=0", RX_DATA, RX_EMPTY, exp);
      end
      pulseRead();
    end
    vectors++;
    if (RX_EMPTY !== 1'b1) begin miscompares++; $display("FAIL wrap_drained got=%b exp=1", RX_EMPTY); end
  endtask

  task automatic test_reset_mid_frame();
    sendBit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b0, 1'b1, 1'b0);
    @(negedge PCLK);
    CLEAR_B  = 1'b0;
    SSPCLKIN = 1'b0;
    sb.delete();
    @(negedge PCLK);
    vectors++;
    if (RX_EMPTY !== 1'b1 || RX_DATA !== 8'h00 || SSPRXINTR !== 1'b0 || RX_OVERRUN !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs got=%h/%b/%b/%b exp=00/1/0/0", RX_DATA, RX_EMPTY, SSPRXINTR, RX_OVERRUN);
    end
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    sendFrame(8'h7E, 1'b1, 1'b0, 1'b0);
    settle();
    exp = sb.pop_front();
    vectors++;
    if (RX_DATA !== exp || RX_EMPTY !== 1'b0) begin
      miscompares++; $display("FAIL midreset_data got=%h/empty=%b exp=%h/empty=0", RX_DATA, RX_EMPTY, exp);
    end
    pulseRead();
    vectors++;
    if (RX_EMPTY !== 1'b1) begin miscompares++; $display("FAIL midreset_drained got=%b exp=1", RX_EMPTY); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    expOvr      = 1'b0;
    CLEAR_B     = 1'b0;
    SSPCLKIN    = 1'b0;
    SSPFSSIN    = 1'b0;
    SSPRXD      = 1'b0;
    RX_RD       = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_read_write_full();
    test_wrap();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
